fifo_wr_arbiter: RTL
====================

# fifo_wr_arbiter

Round-robin write-port arbiter that shares the single write port of the 8-deep synchronous FIFO among NUM_REQ producers. Each producer gets a valid/ready handshake. Grants are held for bursts of up to MAX_BURST words. The block never issues a write while the FIFO reports full. It sits directly in front of the FIFO's write/data_in/full pins; the FIFO read side is untouched.

## Interface
- NUM_REQ, 4: number of requesters, 2..8.
- DATA_W, 8: data width; matches the FIFO data_in width.
- MAX_BURST, 4: maximum words per grant, 1..8.
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- req_valid  input  NUM_REQ  per-requester word-available flag.
- req_last  input  NUM_REQ  marks the final word of a requester's burst.
- req_data  input  NUM_REQ*DATA_W  requester i data at bits [i*DATA_W +: DATA_W].
- req_ready  output  NUM_REQ  one-hot or zero; a word transfers when req_valid[i] && req_ready[i].
- fifo_full  input  1  FIFO full flag.
- fifo_write  output  1  FIFO write strobe.
- fifo_data_in  output  DATA_W  FIFO write data.
- grant_id  output  clog2(NUM_REQ)  registered index of the current/last grantee.
- busy  output  1  registered; 1 while in BURST.

## Operation
- FSM with two states, IDLE and BURST.
- Reset state is IDLE. Reset values:
  - rr_ptr=0, grant_id=0, beat_cnt=0, busy=0.
  - req_ready=0, fifo_write=0, fifo_data_in=0.
- IDLE:
  - req_ready=0 and fifo_write=0.
  - If any req_valid is set, pick the first set bit searching rr_ptr, rr_ptr+1, … modulo NUM_REQ.
  - Register that index into grant_id, set busy=1, clear beat_cnt, and go to BURST.
  - Otherwise stay in IDLE.
- BURST, with g = grant_id:
  - req_ready[g] = !fifo_full; all other req_ready bits are 0.
  - fifo_write = req_valid[g] && !fifo_full.
  - fifo_data_in = req_data[g] when fifo_write=1, else 0.
  - Accept = fifo_write. On accept, beat_cnt increments.
- Burst end:
  - Accept with req_last[g]=1, or accept with beat_cnt==MAX_BURST-1.
  - Or req_valid[g]=0 while fifo_full=0 (producer bubble), with no write that cycle.
  - On burst end: go to IDLE, set busy=0, rr_ptr <= (g+1) mod NUM_REQ.
- fifo_full=1 in BURST:
  - Stall; no accept, beat_cnt and grant held.
  - A deasserted req_valid[g] during full does not end the burst.
- beat_cnt width is clog2(MAX_BURST)+1. It never exceeds MAX_BURST-1 before the burst ends.
- Requesters that are not granted see req_ready=0. Their valid/data are ignored and no words are dropped; a producer holds its data until accepted.
- grant_id keeps its last value in IDLE until the next arbitration.

## Timing
- Arbitration latency: req_valid observed in IDLE at edge N gives BURST from edge N. The earliest accept is in the cycle after edge N.
- Writes are combinational from req_valid/fifo_full in BURST. The FIFO samples fifo_write/fifo_data_in on the same edge as the requester handshake.
- One mandatory IDLE cycle follows every burst.
  - Peak throughput is MAX_BURST words per MAX_BURST+1 cycles.
  - A single continuously-valid requester also sees this gap.
- fifo_full is sampled combinationally each cycle. A full flag rising as the result of this cycle's write blocks the next cycle's write.
- Reset asserted mid-burst: immediate return to IDLE with all reset values. No partial state persists; an in-flight word not yet clocked is not written.
- Reset deassertion: the first arbitration can occur on the first rising edge with reset=1.

## Test plan
- Single requester: req 0 sends bytes 0x11,0x22,0x33 with last on 0x33 → three consecutive fifo_write pulses carrying 0x11,0x22,0x33, then one IDLE cycle, busy 1→0, rr_ptr=1.
- Contention: all four requesters continuously valid, each sending 1-word bursts with last → grant_id sequence 0,1,2,3,0, one write per two cycles.
- Burst cap: MAX_BURST=4, req 2 valid for 6 words with no last → words 1–4 accepted, grant released; req 2 re-granted only after requesters 3,0,1 are checked, then words 5–6 are written.
- Full stall: fifo_full forced high after 2 of 3 words → fifo_write=0 and req_ready=0 while full, beat_cnt holds at 2; on release the 3rd word is written and the burst ends.
- Bubble: granted req 1 drops valid for one cycle with fifo_full=0 → burst ends with no write, busy=0, next grant goes to req 2 if it is valid.
- Reset mid-burst: reset=0 during beat 2 → fifo_write=0, busy=0, grant_id=0 immediately; after release, grant order restarts from requester 0.

Source files
------------

// File: rtl/fifo_wr_arbiter_if.sv
// Handshake bundle between NUM_REQ producers, the write arbiter and the FIFO write pins.
// master = arbiter side, slave = producers/FIFO side.
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
);
  localparam int IDW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_last;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      fifo_full;
  logic                      fifo_write;
  logic [DATA_W-1:0]         fifo_data_in;
  logic [IDW-1:0]            grant_id;
  logic                      busy;

  modport master (
    input  req_valid, req_last, req_data, fifo_full,
    output req_ready, fifo_write, fifo_data_in, grant_id, busy
  );

  modport slave (
    output req_valid, req_last, req_data, fifo_full,
    input  req_ready, fifo_write, fifo_data_in, grant_id, busy
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers,
// holding each grant for a burst of up to MAX_BURST words.
module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              reset,
  fifo_wr_arbiter_if.master bus
);
  localparam int IDW = $clog2(NUM_REQ);
  localparam int BCW = $clog2(MAX_BURST) + 1;

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  state_t state, state_nxt;

  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] grant_id;
  logic [BCW-1:0] beat_cnt;
  logic           busy;

  logic [NUM_REQ-1:0][DATA_W-1:0] data_a;
  logic [NUM_REQ-1:0]             sel;
  logic [NUM_REQ-1:0]             ready_n;
  logic                           write_n;
  logic [DATA_W-1:0]              data_n;

  logic                 g_valid, g_last, accept, burst_end;
  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0]   rot;
  logic [IDW-1:0]       first_k, pick, g_next;
  logic [IDW:0]         pick_sum, next_sum;
  logic                 pick_vld;

  assign data_a = bus.req_data;

  // One-hot decode of the current grantee.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_sel
    assign sel[i] = (grant_id == IDW'(i));
  end

  assign g_valid = bus.req_valid[grant_id];
  assign g_last  = bus.req_last[grant_id];
  assign accept  = (state == BURST) && g_valid && !bus.fifo_full;

  // A producer bubble only ends the burst when the FIFO could have taken a word.
  assign burst_end = (state == BURST) &&
                     ((accept && (g_last || beat_cnt == BCW'(MAX_BURST - 1))) ||
                      (!g_valid && !bus.fifo_full));

  // Rotate requests so bit 0 is rr_ptr, find the first set bit, then un-rotate.
  always_comb begin
    dbl      = {bus.req_valid, bus.req_valid} >> rr_ptr;
    rot      = dbl[NUM_REQ-1:0];
    first_k  = '0;
    pick_vld = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        first_k  = IDW'(k);
        pick_vld = 1'b1;
      end
    end
    pick_sum = {1'b0, rr_ptr} + {1'b0, first_k};
    if (pick_sum >= (IDW+1)'(NUM_REQ)) pick_sum = pick_sum - (IDW+1)'(NUM_REQ);
    pick = pick_sum[IDW-1:0];
  end

  always_comb begin
    next_sum = {1'b0, grant_id} + (IDW+1)'(1);
    if (next_sum >= (IDW+1)'(NUM_REQ)) next_sum = '0;
    g_next = next_sum[IDW-1:0];
  end

  // FSM: state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_vld)  state_nxt = BURST;
      BURST:   if (burst_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM: outputs; writes are combinational so the FIFO and producer see the same edge.
  always_comb begin
    ready_n = '0;
    write_n = 1'b0;
    data_n  = '0;
    if (state == BURST) begin
      ready_n = sel & {NUM_REQ{!bus.fifo_full}};
      write_n = g_valid && !bus.fifo_full;
      if (write_n) data_n = data_a[grant_id];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr   <= '0;
      grant_id <= '0;
      beat_cnt <= '0;
      busy     <= 1'b0;
    end else if (state == IDLE) begin
      if (pick_vld) begin
        grant_id <= pick;
        busy     <= 1'b1;
        beat_cnt <= '0;
      end
    end else begin
      if (accept) beat_cnt <= beat_cnt + BCW'(1);
      if (burst_end) begin
        busy   <= 1'b0;
        rr_ptr <= g_next;
      end
    end
  end

  assign bus.req_ready    = ready_n;
  assign bus.fifo_write   = write_n;
  assign bus.fifo_data_in = data_n;
  assign bus.grant_id     = grant_id;
  assign bus.busy         = busy;
endmodule
